// File: rtl/ex_div_pkg.sv
// Shared constants for the EX-stage divider: op codes, bus widths, reset level
// and divider FSM state encodings.
package ex_div_pkg;

  localparam int REG_BUS_W = 32;
  localparam int ALU_OP_W  = 8;

  localparam logic [ALU_OP_W-1:0]  EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [ALU_OP_W-1:0]  EXE_DIVU_OP = 8'b0001_1011;
  localparam logic [ALU_OP_W-1:0]  EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [REG_BUS_W-1:0] ZERO_WORD   = '0;
  localparam logic                 RST_ENABLE  = 1'b1;

  localparam logic [1:0] DIV_FREE    = 2'b00;
  localparam logic [1:0] DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] DIV_ON      = 2'b10;
  localparam logic [1:0] DIV_END     = 2'b11;

endpackage

// File: rtl/ex_div_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder and subtracts the divisor when it fits.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic              bit_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              q_o
);

  logic [DATA_W:0] part;
  logic [DATA_W:0] diff;

  // The remainder is always below the divisor, so a set MSB after the
  // subtraction can only mean a borrow.
  always_comb begin
    part  = {rem_i, bit_i};
    diff  = part - {1'b0, divisor_i};
    q_o   = ~diff[DATA_W];
    rem_o = q_o ? diff[DATA_W-1:0] : part[DATA_W-1:0];
  end

endmodule

// File: rtl/ex_div.sv
// Multi-cycle signed/unsigned divider in EX; stalls the front of the pipe while busy.
// Optional macro DIV_FAST_PATH_EN: skips RUN when |divisor| > |dividend|.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ALU_OP_W-1:0] ex_aluop,
  input  logic [DATA_W-1:0]   ex_reg1,
  input  logic [DATA_W-1:0]   ex_reg2,
  input  logic                annul_i,
  output logic                stallreq_o,
  output logic [DATA_W-1:0]   div_hi_o,
  output logic [DATA_W-1:0]   div_lo_o,
  output logic                div_valid_o
);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dq_q, dq_d;
  logic [DATA_W-1:0] divisor_q, divisor_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic              sign_q_q, sign_q_d;
  logic              sign_r_q, sign_r_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic              is_div, is_signed, stall_c;
  logic [DATA_W-1:0] abs1, abs2, rem_nx, quo_nx;
  logic              q_bit;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dq_q[DATA_W-1]),
    .divisor_i (divisor_q),
    .rem_o     (rem_nx),
    .q_o       (q_bit)
  );

  // dq_q shifts dividend bits out of the top and quotient bits in at the bottom.
  always_comb begin
    is_div    = (ex_aluop == EXE_DIV_OP) || (ex_aluop == EXE_DIVU_OP);
    is_signed = (ex_aluop == EXE_DIV_OP);
    abs1      = (is_signed && ex_reg1[DATA_W-1]) ? -ex_reg1 : ex_reg1;
    abs2      = (is_signed && ex_reg2[DATA_W-1]) ? -ex_reg2 : ex_reg2;
    quo_nx    = {dq_q[DATA_W-2:0], q_bit};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dq_d      = dq_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    sign_q_d  = sign_q_q;
    sign_r_d  = sign_r_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stall_c   = 1'b0;
    case (state_q)
      DIV_FREE: begin
        if (is_div && !annul_i) begin
          stall_c   = 1'b1;
          dq_d      = abs1;
          divisor_d = abs2;
          rem_d     = '0;
          cnt_d     = '0;
          sign_q_d  = is_signed & (ex_reg1[DATA_W-1] ^ ex_reg2[DATA_W-1]);
          sign_r_d  = is_signed & ex_reg1[DATA_W-1];
          if (ex_reg2 == '0)
            state_d = DIV_BY_ZERO;
`ifdef DIV_FAST_PATH_EN
          else if (abs2 > abs1)
            state_d = DIV_BY_ZERO;
`endif
          else
            state_d = DIV_ON;
        end
      end
      DIV_BY_ZERO: begin
        if (annul_i) begin
          state_d = DIV_FREE;
          cnt_d   = '0;
        end else begin
          stall_c = 1'b1;
          state_d = DIV_END;
          lo_d    = '0;
`ifdef DIV_FAST_PATH_EN
          // Shared with the fast path: a non-zero divisor here means the quotient is 0.
          if (divisor_q == '0)
            hi_d = '0;
          else
            hi_d = sign_r_q ? -dq_q : dq_q;
`else
          hi_d    = '0;
`endif
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
          cnt_d   = '0;
        end else begin
          stall_c = 1'b1;
          rem_d   = rem_nx;
          dq_d    = quo_nx;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = DIV_END;
            cnt_d   = '0;
            lo_d    = sign_q_q ? -quo_nx : quo_nx;
            hi_d    = sign_r_q ? -rem_nx : rem_nx;
          end
        end
      end
      default: begin
        state_d = DIV_FREE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      dq_q      <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      sign_q_q  <= 1'b0;
      sign_r_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dq_q      <= dq_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      sign_q_q  <= sign_q_d;
      sign_r_q  <= sign_r_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign stallreq_o  = stall_c & ~rst;
  assign div_hi_o    = hi_q;
  assign div_lo_o    = lo_q;
  assign div_valid_o = (state_q == DIV_END);

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: directed divides push expected HI/LO, a monitor
// pops and compares on every div_valid_o pulse.
module tb_ex_div;
  import ex_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic        annul_i;
  logic        stallreq_o;
  logic [31:0] div_hi_o;
  logic [31:0] div_lo_o;
  logic        div_valid_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

`ifdef DIV_FAST_PATH_EN
  localparam int FAST_STALL = 2;
`else
  localparam int FAST_STALL = 33;
`endif

  ex_div dut (
    .clk         (clk),
    .rst         (rst),
    .ex_aluop    (ex_aluop),
    .ex_reg1     (ex_reg1),
    .ex_reg2     (ex_reg2),
    .annul_i     (annul_i),
    .stallreq_o  (stallreq_o),
    .div_hi_o    (div_hi_o),
    .div_lo_o    (div_lo_o),
    .div_valid_o (div_valid_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one divide, holds the op through the stall, and checks stall length.
  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                               input int exp_stall, input string name);
    int stall_cnt;
    exp_q.push_back({exp_hi, exp_lo});
    @(posedge clk); #1;
    ex_aluop = op;
    ex_reg1  = a;
    ex_reg2  = b;
    stall_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stallreq_o) stall_cnt++;
      else break;
    end
    checkOutput({name, "_stall_cycles"}, stall_cnt, exp_stall);
    checkOutput({name, "_valid_after_stall"}, {31'b0, div_valid_o}, 32'd1);
    ex_aluop = EXE_NOP_OP;
  endtask

  task automatic expectQuiet(input int cycles, input string name);
    int valid_cnt;
    valid_cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (div_valid_o || stallreq_o) valid_cnt++;
    end
    checkOutput({name, "_quiet"}, valid_cnt, 0);
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (div_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_valid: got hi=%h lo=%h expected no pulse", div_hi_o, div_lo_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        checkOutput("result_hi", div_hi_o, e[63:32]);
        checkOutput("result_lo", div_lo_o, e[31:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    ex_aluop = EXE_NOP_OP;
    ex_reg1  = '0;
    ex_reg2  = '0;
    annul_i  = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_stall", {31'b0, stallreq_o}, 32'd0);
    checkOutput("reset_valid", {31'b0, div_valid_o}, 32'd0);
    checkOutput("reset_hi", div_hi_o, 32'h0);
    checkOutput("reset_lo", div_lo_o, 32'h0);
    rst = 1'b0;

    applyStimulus(EXE_DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, 33, "divu_100_7");
    applyStimulus(EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, "div_m7_2");
    applyStimulus(EXE_DIV_OP, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33, "div_7_m2");
    applyStimulus(EXE_DIV_OP, 32'd5, 32'd0, 32'd0, 32'd0, 2, "div_5_0");
    applyStimulus(EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33, "div_min_m1");

    // Annul in RUN cycle 10: stall drops at once and the result is discarded.
    @(posedge clk); #1;
    ex_aluop = EXE_DIVU_OP;
    ex_reg1  = 32'hFFFFFFFF;
    ex_reg2  = 32'h10;
    @(negedge clk);
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    #1;
    checkOutput("annul_stall_drop", {31'b0, stallreq_o}, 32'd0);
    @(posedge clk); #1;
    annul_i  = 1'b0;
    ex_aluop = EXE_NOP_OP;
    expectQuiet(40, "after_annul");
    applyStimulus(EXE_DIVU_OP, 32'd9, 32'd3, 32'd0, 32'd3, 33, "divu_9_3");

    applyStimulus(EXE_DIVU_OP, 32'd20, 32'd6, 32'd2, 32'd3, 33, "b2b_first");
    applyStimulus(EXE_DIVU_OP, 32'd21, 32'd4, 32'd1, 32'd5, 33, "b2b_second");

    // Annul while idle blocks acceptance.
    @(posedge clk); #1;
    ex_aluop = EXE_DIV_OP;
    ex_reg1  = 32'd10;
    ex_reg2  = 32'd2;
    annul_i  = 1'b1;
    @(negedge clk);
    checkOutput("idle_annul_block", {31'b0, stallreq_o}, 32'd0);
    @(posedge clk); #1;
    annul_i  = 1'b0;
    ex_aluop = EXE_NOP_OP;
    expectQuiet(5, "idle_annul");

    // Reset on RUN cycle 15 discards the division and clears the outputs.
    @(posedge clk); #1;
    ex_aluop = EXE_DIVU_OP;
    ex_reg1  = 32'd1000;
    ex_reg2  = 32'd3;
    @(negedge clk);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_stall_low", {31'b0, stallreq_o}, 32'd0);
    @(posedge clk); #1;
    rst      = 1'b0;
    ex_aluop = EXE_NOP_OP;
    checkOutput("rst_hi", div_hi_o, 32'h0);
    checkOutput("rst_lo", div_lo_o, 32'h0);
    checkOutput("rst_valid", {31'b0, div_valid_o}, 32'd0);
    expectQuiet(40, "after_rst");

    applyStimulus(EXE_DIVU_OP, 32'd3, 32'd10, 32'd3, 32'd0, FAST_STALL, "divu_3_10");

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
